// File: rtl/frame_plot_scheduler_if.sv
// Bus bundle between the frame scheduler, the pixel/overlay renderers and the VGA adapter.
interface frame_plot_scheduler_if;
  logic       run;
  logic       frame_clk;
  logic       rend_en;
  logic [7:0] rend_x;
  logic [7:0] rend_y;
  logic [2:0] rend_color;
  logic       rend_plot;
  logic       ovl_start;
  logic [7:0] ovl_x;
  logic [7:0] ovl_y;
  logic [2:0] ovl_color;
  logic       ovl_plot;
  logic       ovl_done;
  logic [7:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_color;
  logic       vga_plot;
  logic       busy;
  logic       overrun;
  logic [15:0] frame_count;

  // Scheduler side
  modport master (
    input  run, rend_x, rend_y, rend_color, rend_plot,
    input  ovl_x, ovl_y, ovl_color, ovl_plot, ovl_done,
    output frame_clk, rend_en, ovl_start,
    output vga_x, vga_y, vga_color, vga_plot,
    output busy, overrun, frame_count
  );

  // Renderers / game logic / VGA adapter side
  modport slave (
    output run, rend_x, rend_y, rend_color, rend_plot,
    output ovl_x, ovl_y, ovl_color, ovl_plot, ovl_done,
    input  frame_clk, rend_en, ovl_start,
    input  vga_x, vga_y, vga_color, vga_plot,
    input  busy, overrun, frame_count
  );
endinterface

// File: rtl/frame_plot_scheduler.sv
// Per-frame sequencer: frame timer -> snapshot -> renderer sweep -> overlay pass,
// and arbiter of the single VGA plot port between the two renderers.
module frame_plot_scheduler #(
  parameter int unsigned X_MAX       = 159,
  parameter int unsigned Y_MAX       = 119,
  parameter int unsigned FRAME_DIV   = 833333,
  parameter int unsigned OVL_TIMEOUT = 4096
) (
  input logic clk,
  input logic reset,
  frame_plot_scheduler_if.master bus
);

  localparam int unsigned PIX_W     = 15;
  localparam int unsigned PIX_TOTAL = (X_MAX + 1) * (Y_MAX + 1);
  localparam int unsigned TIMER_W   = $clog2(FRAME_DIV);
  localparam int unsigned OVL_W     = $clog2(OVL_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SNAP      = 3'd1,
    SWEEP     = 3'd2,
    OVL_START = 3'd3,
    OVERLAY   = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] frameTimer;
  logic [PIX_W-1:0]   pixCnt;
  logic [OVL_W-1:0]   ovlTimer;
  logic               pending;
  logic               tick;
  logic               startFrame;
  logic               tickOverrun;

  logic               frameClk;
  logic               rendEn;
  logic               ovlStart;
  logic               busyR;
  logic               overrunR;
  logic [15:0]        frameCount;
  logic [7:0]         vgaX;
  logic [7:0]         vgaY;
  logic [2:0]         vgaColor;
  logic               vgaPlot;

  logic [7:0]         grantX;
  logic [7:0]         grantY;
  logic [2:0]         grantColor;
  logic               grantPlot;

  assign tick        = (frameTimer == TIMER_W'(FRAME_DIV - 1));
  assign startFrame  = (state == IDLE) && pending && bus.run;
  // A second tick is only an overrun when it is not consumed by a frame start this cycle.
  assign tickOverrun = tick && pending && !startFrame;

  // Free-running frame timer, independent of run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frameTimer <= '0;
    end else if (tick) begin
      frameTimer <= '0;
    end else begin
      frameTimer <= frameTimer + TIMER_W'(1);
    end
  end

  // Single-slot pending tick; a tick coinciding with the frame start keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (tick) begin
      pending <= 1'b1;
    end else if (startFrame) begin
      pending <= 1'b0;
    end
  end

  // Frame sequencing FSM with registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pixCnt     <= '0;
      ovlTimer   <= '0;
      frameClk   <= 1'b0;
      rendEn     <= 1'b0;
      ovlStart   <= 1'b0;
      busyR      <= 1'b0;
      overrunR   <= 1'b0;
      frameCount <= '0;
    end else begin
      frameClk <= 1'b0;
      ovlStart <= 1'b0;
      if (tickOverrun) begin
        overrunR <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (startFrame) begin
            state    <= SNAP;
            frameClk <= 1'b1;
            busyR    <= 1'b1;
          end
        end
        SNAP: begin
          pixCnt <= '0;
          rendEn <= 1'b1;
          state  <= SWEEP;
        end
        SWEEP: begin
          if (bus.rend_plot) begin
            pixCnt <= pixCnt + PIX_W'(1);
            if (pixCnt == PIX_W'(PIX_TOTAL - 1)) begin
              rendEn   <= 1'b0;
              ovlStart <= 1'b1;
              state    <= OVL_START;
            end
          end
        end
        OVL_START: begin
          ovlTimer <= '0;
          state    <= OVERLAY;
        end
        OVERLAY: begin
          if (bus.ovl_done) begin
            state <= DONE;
          end else if (ovlTimer == OVL_W'(OVL_TIMEOUT - 1)) begin
            overrunR <= 1'b1;
            state    <= DONE;
          end else begin
            ovlTimer <= ovlTimer + OVL_W'(1);
          end
        end
        DONE: begin
          frameCount <= frameCount + 16'd1;
          busyR      <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          rendEn <= 1'b0;
          busyR  <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Plot-port grant: renderer during SWEEP, overlay during OVERLAY, nobody otherwise.
  always_comb begin
    grantX     = '0;
    grantY     = '0;
    grantColor = '0;
    grantPlot  = 1'b0;
    case (state)
      SWEEP: begin
        grantX     = bus.rend_x;
        grantY     = bus.rend_y;
        grantColor = bus.rend_color;
        grantPlot  = bus.rend_plot;
      end
      OVERLAY: begin
        grantX     = bus.ovl_x;
        grantY     = bus.ovl_y;
        grantColor = bus.ovl_color;
        grantPlot  = bus.ovl_plot;
      end
      default: begin
        grantPlot = 1'b0;
      end
    endcase
  end

  // Registered plot path; off-screen pixels update coordinates but never strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vgaX     <= '0;
      vgaY     <= '0;
      vgaColor <= '0;
      vgaPlot  <= 1'b0;
    end else begin
      vgaPlot <= grantPlot && (grantX <= 8'(X_MAX)) && (grantY <= 8'(Y_MAX));
      if (grantPlot) begin
        vgaX     <= grantX;
        vgaY     <= grantY;
        vgaColor <= grantColor;
      end
    end
  end

  assign bus.frame_clk   = frameClk;
  assign bus.rend_en     = rendEn;
  assign bus.ovl_start   = ovlStart;
  assign bus.busy        = busyR;
  assign bus.overrun     = overrunR;
  assign bus.frame_count = frameCount;
  assign bus.vga_x       = vgaX;
  assign bus.vga_y       = vgaY;
  assign bus.vga_color   = vgaColor;
  assign bus.vga_plot    = vgaPlot;

endmodule

// File: tb/tb_frame_plot_scheduler.sv
// Directed bench for frame_plot_scheduler on a 4x2 screen with a 40-cycle frame.
module tb_frame_plot_scheduler;
  localparam int unsigned XM = 3;
  localparam int unsigned YM = 1;
  localparam int unsigned FD = 40;
  localparam int unsigned OT = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  frame_plot_scheduler_if bus();

  frame_plot_scheduler #(
    .X_MAX(XM), .Y_MAX(YM), .FRAME_DIV(FD), .OVL_TIMEOUT(OT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic       rp;
    logic [7:0] rx;
    logic [7:0] ry;
    logic [2:0] rc;
    logic       op;
    logic [7:0] ox;
    logic [7:0] oy;
    logic [2:0] oc;
    logic       ePlot;
    logic [7:0] eX;
    logic [7:0] eY;
    logic [2:0] eC;
    logic       eRendEn;
    logic       eOvlStart;
  } vec_t;

  vec_t vecs[15];
  int   nAsserts = 0;
  int   nFail    = 0;

  function automatic vec_t mk(input logic rp, input int rx, input int ry, input int rc,
                              input logic op, input int ox, input int oy, input int oc,
                              input logic ep, input int ex, input int ey, input int ec,
                              input logic er, input logic eo);
    vec_t v;
    v.rp = rp; v.rx = 8'(rx); v.ry = 8'(ry); v.rc = 3'(rc);
    v.op = op; v.ox = 8'(ox); v.oy = 8'(oy); v.oc = 3'(oc);
    v.ePlot = ep; v.eX = 8'(ex); v.eY = 8'(ey); v.eC = 3'(ec);
    v.eRendEn = er; v.eOvlStart = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nAsserts++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearInputs();
    bus.rend_plot = 1'b0; bus.rend_x = '0; bus.rend_y = '0; bus.rend_color = '0;
    bus.ovl_plot  = 1'b0; bus.ovl_x  = '0; bus.ovl_y  = '0; bus.ovl_color  = '0;
    bus.ovl_done  = 1'b0;
  endtask

  task automatic drvRend(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
    bus.rend_plot = 1'b1; bus.rend_x = x; bus.rend_y = y; bus.rend_color = c;
  endtask

  initial begin
    logic fcSeen;
    logic busySeen;

    // Sweep and overlay vectors; frame 1 enters SWEEP before vecs[0] is applied.
    //               rend: p  x  y  c  ovl: p  x  y  c  exp: plot x  y  c  rendEn ovlStart
    vecs[0]  = mk(0, 0, 0, 0, 1, 1, 0, 7, 0, 0, 0, 0, 1, 0);
    vecs[1]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    vecs[2]  = mk(1, 1, 0, 2, 0, 0, 0, 0, 1, 1, 0, 2, 1, 0);
    vecs[3]  = mk(1, 5, 0, 3, 0, 0, 0, 0, 0, 5, 0, 3, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 3, 1, 0);
    vecs[5]  = mk(1, 2, 0, 4, 0, 0, 0, 0, 1, 2, 0, 4, 1, 0);
    vecs[6]  = mk(1, 3, 0, 5, 0, 0, 0, 0, 1, 3, 0, 5, 1, 0);
    vecs[7]  = mk(1, 0, 1, 6, 0, 0, 0, 0, 1, 0, 1, 6, 1, 0);
    vecs[8]  = mk(1, 1, 1, 7, 0, 0, 0, 0, 1, 1, 1, 7, 1, 0);
    vecs[9]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 1);
    vecs[10] = mk(1, 0, 0, 1, 1, 2, 0, 3, 0, 3, 1, 0, 0, 0);
    vecs[11] = mk(1, 2, 1, 5, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 1, 1, 0, 6, 1, 1, 0, 6, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 1, 7, 0, 2, 0, 7, 0, 2, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 1, 0, 1, 3, 1, 0, 1, 3, 0, 0);

    reset = 1'b1;
    bus.run = 1'b1;
    clearInputs();
    step(3);
    chk("reset_ctl", 32'({bus.frame_clk, bus.rend_en, bus.ovl_start, bus.vga_plot, bus.busy, bus.overrun}), 32'd0);
    chk("reset_pix", 32'({bus.vga_x, bus.vga_y, bus.vga_color}), 32'd0);
    chk("reset_fc", 32'(bus.frame_count), 32'd0);
    reset = 1'b0;

    // Tick after edge 39, pending at edge 40, SNAP (frame_clk) at edge 41.
    fcSeen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (bus.frame_clk) fcSeen = 1'b1;
    end
    chk("no_early_frame_clk", 32'(fcSeen), 32'd0);
    step(1);
    chk("frame_clk_pulse", 32'(bus.frame_clk), 32'd1);
    chk("busy_in_snap", 32'(bus.busy), 32'd1);
    step(1);
    chk("frame_clk_one_cycle", 32'(bus.frame_clk), 32'd0);
    chk("rend_en_sweep", 32'(bus.rend_en), 32'd1);

    for (int i = 0; i < 15; i++) begin
      bus.rend_plot = vecs[i].rp; bus.rend_x = vecs[i].rx; bus.rend_y = vecs[i].ry; bus.rend_color = vecs[i].rc;
      bus.ovl_plot  = vecs[i].op; bus.ovl_x  = vecs[i].ox; bus.ovl_y  = vecs[i].oy; bus.ovl_color  = vecs[i].oc;
      step(1);
      chk($sformatf("vec%0d_plot", i), 32'(bus.vga_plot), 32'(vecs[i].ePlot));
      chk($sformatf("vec%0d_x", i), 32'(bus.vga_x), 32'(vecs[i].eX));
      chk($sformatf("vec%0d_y", i), 32'(bus.vga_y), 32'(vecs[i].eY));
      chk($sformatf("vec%0d_color", i), 32'(bus.vga_color), 32'(vecs[i].eC));
      chk($sformatf("vec%0d_rend_en", i), 32'(bus.rend_en), 32'(vecs[i].eRendEn));
      chk($sformatf("vec%0d_ovl_start", i), 32'(bus.ovl_start), 32'(vecs[i].eOvlStart));
    end
    clearInputs();

    // Overlay has used 4 of its 16 cycles; never raise ovl_done.
    step(11);
    chk("ovl_pre_timeout_busy", 32'(bus.busy), 32'd1);
    chk("ovl_pre_timeout_overrun", 32'(bus.overrun), 32'd0);
    step(1);
    chk("ovl_timeout_overrun", 32'(bus.overrun), 32'd1);
    chk("ovl_timeout_done_busy", 32'(bus.busy), 32'd1);
    step(1);
    chk("frame_count_1", 32'(bus.frame_count), 32'd1);
    chk("idle_not_busy", 32'(bus.busy), 32'd0);

    // run=0: the tick at edge 80 stays pending while IDLE holds.
    bus.run = 1'b0;
    fcSeen = 1'b0;
    busySeen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step(1);
      if (bus.frame_clk) fcSeen = 1'b1;
      if (bus.busy) busySeen = 1'b1;
    end
    chk("run0_no_frame", 32'({fcSeen, busySeen}), 32'd0);
    bus.run = 1'b1;
    step(1);
    chk("pending_retained_frame_clk", 32'(bus.frame_clk), 32'd1);
    step(1);
    chk("frame2_rend_en", 32'(bus.rend_en), 32'd1);
    drvRend(8'd2, 8'd1, 3'd3);
    step(1);
    chk("frame2_plot", 32'({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_color}), 32'({1'b1, 8'd2, 8'd1, 3'd3}));

    // Asynchronous reset mid-SWEEP takes effect before the next edge.
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_ctl", 32'({bus.rend_en, bus.vga_plot, bus.busy, bus.overrun}), 32'd0);
    chk("async_rst_fc", 32'(bus.frame_count), 32'd0);
    clearInputs();
    step(2);
    reset = 1'b0;

    // Stalled sweep: pending again at edge 80, third tick at edge 120 is an overrun.
    for (int k = 1; k <= 120; k++) begin
      step(1);
      if (k == 41) chk("stall_frame_clk", 32'(bus.frame_clk), 32'd1);
      if (k == 80) chk("stall_second_tick_no_overrun", 32'(bus.overrun), 32'd0);
      if (k == 119) chk("stall_still_sweeping", 32'({bus.busy, bus.rend_en, bus.overrun}), 32'b110);
      if (k == 120) chk("stall_third_tick_overrun", 32'(bus.overrun), 32'd1);
    end

    for (int i = 0; i < 8; i++) begin
      drvRend(8'(i % 4), 8'(i / 4), 3'(i));
      step(1);
      chk($sformatf("stall_px%0d", i), 32'({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_color}),
          32'({1'b1, 8'(i % 4), 8'(i / 4), 3'(i)}));
      chk($sformatf("stall_px%0d_ovl_start", i), 32'(bus.ovl_start), 32'(i == 7));
    end
    clearInputs();
    step(1);
    chk("stall_ovl_start_single", 32'(bus.ovl_start), 32'd0);
    bus.ovl_done = 1'b1;
    step(1);
    chk("stall_done_state", 32'({bus.busy, bus.overrun, bus.vga_plot}), 32'b110);
    chk("stall_fc_before_done", 32'(bus.frame_count), 32'd0);
    bus.ovl_done = 1'b0;
    step(1);
    chk("stall_fc_after_done", 32'(bus.frame_count), 32'd1);
    chk("stall_idle", 32'(bus.busy), 32'd0);
    step(1);
    chk("next_frame_immediate", 32'(bus.frame_clk), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
